// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable data width, parity and stop bits,
// input synchroniser and 3-sample majority vote. Break detect: UART_RX_BREAK_DETECT_EN.
//
// state      | meaning
// IDLE       | line idle, waiting for a low synchronised sample
// START      | confirm start bit at its midpoint (false-start rejection)
// DATA       | sample DATA_BITS data bits, one per bit period
// PARITY     | sample the parity bit (PARITY_MODE != 0 only)
// STOP       | sample STOP_BITS stop bits, latch framing error
// DONE       | one-cycle output strobe
// BREAK_WAIT | (break detect only) wait for line high for one bit period
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;
`endif

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          bit_idx_q;
    logic                   stop_idx_q;
    logic                   sync1_q;
    logic                   sync2_q;
    logic [2:0]             vote_sr_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q;
    logic                   ferr_q;
    logic                   dv_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   perr_q;
    logic                   frame_q;

    logic vote;
    logic par_calc;
    logic par_err_d;
    logic frame_err_d;

    assign vote = (vote_sr_q[0] & vote_sr_q[1]) |
                  (vote_sr_q[0] & vote_sr_q[2]) |
                  (vote_sr_q[1] & vote_sr_q[2]);

    assign par_calc    = ^{shift_q, par_bit_q};
    assign par_err_d   = (PARITY_MODE == 1) ? par_calc :
                         (PARITY_MODE == 2) ? ~par_calc : 1'b0;
    // Include the stop sample being taken this cycle, not just earlier ones.
    assign frame_err_d = ferr_q | ~vote;

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q;
    logic brk_d;

    assign brk_d   = (shift_q == '0) && ((PARITY_MODE == 0) || !par_bit_q) && frame_err_d;
    assign o_Break = brk_q;
`else
    assign o_Break = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            vote_sr_q  <= 3'b111;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            dv_q       <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            frame_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            sync1_q   <= i_Rx_Serial;
            sync2_q   <= sync1_q;
            vote_sr_q <= {vote_sr_q[1:0], sync2_q};
            dv_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!sync2_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        ferr_q    <= 1'b0;
                        state_q   <= vote ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
                            stop_idx_q <= 1'b0;
                            par_bit_q  <= 1'b0;
                            state_q    <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q     <= '0;
                        par_bit_q <= vote;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (!vote) begin
                            ferr_q <= 1'b1;
                        end
                        if (stop_idx_q == STOP_LAST) begin
                            dv_q    <= 1'b1;
                            data_q  <= shift_q;
                            perr_q  <= par_err_d;
                            frame_q <= frame_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
                            brk_q   <= brk_d;
`endif
                            state_q <= DONE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                    state_q <= brk_q ? BREAK_WAIT : IDLE;
`else
                    state_q <= IDLE;
`endif
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BREAK_WAIT: begin
                    if (!sync2_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Data    = data_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = frame_q;
    assign o_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8N1 instance plus 7E1 and 8N2 instances
// at a short bit period. Expected values are hand-computed frame contents.
module tb_uart_rx_cfg;

    localparam int CPB   = 87;
    localparam int CPB_S = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    int unsigned cyc = 0;
    int unsigned t_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic       dv0, pe0, fe0, bsy0, br0;
    logic [7:0] d0;
    logic       dv1, pe1, fe1, bsy1, br1;
    logic [6:0] d1;
    logic       dv2, pe2, fe2, bsy2, br2;
    logic [7:0] d2;

    uart_rx_cfg dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0),
        .o_Rx_DV(dv0), .o_Rx_Data(d0), .o_Parity_Err(pe0),
        .o_Frame_Err(fe0), .o_Busy(bsy0), .o_Break(br0)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1),
        .o_Rx_DV(dv1), .o_Rx_Data(d1), .o_Parity_Err(pe1),
        .o_Frame_Err(fe1), .o_Busy(bsy1), .o_Break(br1)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx2),
        .o_Rx_DV(dv2), .o_Rx_Data(d2), .o_Parity_Err(pe2),
        .o_Frame_Err(fe2), .o_Busy(bsy2), .o_Break(br2)
    );

    // Per-instance DV logs, sampled on the falling edge.
    int          n_dv0 = 0, n_dv1 = 0, n_dv2 = 0;
    logic [7:0]  d0_log [32];
    logic        fe0_log [32], pe0_log [32], br0_log [32];
    int unsigned t0_log [32];
    logic [6:0]  d1_log [32];
    logic        pe1_log [32], fe1_log [32];
    logic [7:0]  d2_log [32];
    logic        fe2_log [32], pe2_log [32];

    always @(negedge clk) begin
        if (dv0) begin
            if (n_dv0 < 32) begin
                d0_log[n_dv0]  = d0;
                fe0_log[n_dv0] = fe0;
                pe0_log[n_dv0] = pe0;
                br0_log[n_dv0] = br0;
                t0_log[n_dv0]  = cyc;
            end
            n_dv0++;
        end
        if (dv1) begin
            if (n_dv1 < 32) begin
                d1_log[n_dv1]  = d1;
                pe1_log[n_dv1] = pe1;
                fe1_log[n_dv1] = fe1;
            end
            n_dv1++;
        end
        if (dv2) begin
            if (n_dv2 < 32) begin
                d2_log[n_dv2]  = d2;
                fe2_log[n_dv2] = fe2;
                pe2_log[n_dv2] = pe2;
            end
            n_dv2++;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Sends n bits LSB first; optional one-cycle low glitch at each data-bit midpoint.
    task automatic send_bits(input int sel, input int cpb, input logic [15:0] bits,
                             input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (glitch && c == cpb / 2 && i >= 1 && i <= 8) set_rx(sel, 1'b0);
                else set_rx(sel, bits[i]);
                if (i == 0 && c == 0) t_fall = cyc;
            end
        end
    endtask

    task automatic idle(input int sel, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            set_rx(sel, 1'b1);
        end
    endtask

    int base;
    int busy_cnt;
    int unsigned t_first;
    int lat;

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dv",    {31'b0, dv0}, 32'd0);
        chk("rst_data",  {24'b0, d0},  32'd0);
        chk("rst_busy",  {31'b0, bsy0}, 32'd0);
        chk("rst_flags", {29'b0, pe0, fe0, br0}, 32'd0);

        // Back-to-back 0x3F, 0x3A
        base = n_dv0;
        send_bits(0, CPB, {6'b0, 1'b1, 8'h3F, 1'b0}, 10, 1'b0);
        t_first = t_fall;
        send_bits(0, CPB, {6'b0, 1'b1, 8'h3A, 1'b0}, 10, 1'b0);
        idle(0, 200);
        chk("b2b_count", n_dv0 - base, 32'd2);
        chk("b2b_data0", {24'b0, d0_log[base]}, 32'h3F);
        chk("b2b_data1", {24'b0, d0_log[base+1]}, 32'h3A);
        chk("b2b_err0",  {30'b0, pe0_log[base], fe0_log[base]}, 32'd0);
        chk("b2b_err1",  {30'b0, pe0_log[base+1], fe0_log[base+1]}, 32'd0);
        lat = int'(t0_log[base]) - int'(t_first);
        chk("b2b_latency", {31'b0, (lat >= 827 && lat <= 831)}, 32'd1);

        // 20-cycle low pulse: false start
        base = n_dv0;
        busy_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bsy0) busy_cnt++;
            rx0 = (c < 20) ? 1'b0 : 1'b1;
        end
        chk("false_start_dv", n_dv0 - base, 32'd0);
        chk("false_start_busy_len", {31'b0, (busy_cnt >= 40 && busy_cnt <= 50)}, 32'd1);
        chk("false_start_idle", {31'b0, bsy0}, 32'd0);

        // 0xA5 with midpoint glitches
        base = n_dv0;
        send_bits(0, CPB, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b1);
        idle(0, 100);
        chk("glitch_count", n_dv0 - base, 32'd1);
        chk("glitch_data", {24'b0, d0_log[base]}, 32'hA5);
        chk("glitch_ferr", {31'b0, fe0_log[base]}, 32'd0);

        // Reset during bit 4 of 0xC3 (transmitter also abandons the frame)
        base = n_dv0;
        send_bits(0, CPB, {6'b0, 1'b1, 8'hC3, 1'b0}, 5, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rx0 = 1'b0;
        end
        chk("pre_rst_busy", {31'b0, bsy0}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        chk("midrst_dv",   {31'b0, dv0}, 32'd0);
        chk("midrst_data", {24'b0, d0},  32'd0);
        chk("midrst_busy", {31'b0, bsy0}, 32'd0);
        chk("midrst_flags", {29'b0, pe0, fe0, br0}, 32'd0);
        rst = 1'b0;
        idle(0, 300);
        chk("midrst_no_dv", n_dv0 - base, 32'd0);
        send_bits(0, CPB, {6'b0, 1'b1, 8'h12, 1'b0}, 10, 1'b0);
        idle(0, 100);
        chk("after_rst_count", n_dv0 - base, 32'd1);
        chk("after_rst_data", {24'b0, d0_log[base]}, 32'h12);

        // Line held low for three frame times
        base = n_dv0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            rx0 = 1'b0;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_low_count", n_dv0 - base, 32'd1);
        chk("brk_flag",  {31'b0, br0_log[base]}, 32'd1);
        chk("brk_data",  {24'b0, d0_log[base]},  32'h00);
        chk("brk_ferr",  {31'b0, fe0_log[base]}, 32'd1);
        idle(0, 80);
        chk("brk_busy_hold", {31'b0, bsy0}, 32'd1);
        idle(0, 15);
        chk("brk_busy_release", {31'b0, bsy0}, 32'd0);
        idle(0, 1000);
        chk("brk_total_count", n_dv0 - base, 32'd1);
`else
        chk("hold_low_count", n_dv0 - base, 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("hold_low_data", {24'b0, d0_log[base+k]}, 32'h00);
            chk("hold_low_ferr", {31'b0, fe0_log[base+k]}, 32'd1);
            chk("hold_low_break", {31'b0, br0_log[base+k]}, 32'd0);
        end
        idle(0, 2 * FRAME);
`endif

        // 7E1: 0x41 has two ones, so parity bit 0 is correct
        base = n_dv1;
        send_bits(1, CPB_S, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 1'b0);
        idle(1, 40);
        send_bits(1, CPB_S, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 1'b0);
        idle(1, 40);
        chk("par_count", n_dv1 - base, 32'd2);
        chk("par_ok_data", {25'b0, d1_log[base]}, 32'h41);
        chk("par_ok_err",  {31'b0, pe1_log[base]}, 32'd0);
        chk("par_bad_data", {25'b0, d1_log[base+1]}, 32'h41);
        chk("par_bad_err",  {31'b0, pe1_log[base+1]}, 32'd1);
        chk("par_bad_ferr", {31'b0, fe1_log[base+1]}, 32'd0);

        // 8N2: good frame, then second stop bit low
        base = n_dv2;
        send_bits(2, CPB_S, {5'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11, 1'b0);
        idle(2, 40);
        send_bits(2, CPB_S, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11, 1'b0);
        idle(2, 40);
        chk("stop2_count", n_dv2 - base, 32'd2);
        chk("stop2_ok_ferr", {31'b0, fe2_log[base]}, 32'd0);
        chk("stop2_bad_data", {24'b0, d2_log[base+1]}, 32'h55);
        chk("stop2_bad_ferr", {31'b0, fe2_log[base+1]}, 32'd1);
        chk("stop2_no_perr", {31'b0, pe2_log[base+1]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
